// File: rtl/ccip_c0_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ccip_arb_pkg
// Description : Shared types and helpers for the CCI-P c0 read arbiter.
//               Holds a reduced set of CCI-P c0 header types, the arbiter
//               FSM state type and the round-robin pick function.
// Revision    : 1.0 - initial release
// ============================================================================
package ccip_arb_pkg;

    // Bit position of the most significant requester tag bit inside mdata
    localparam int MDATA_TAG_MSB = 15;

    // Widest requester vector the round-robin helper handles
    localparam int RR_MAX_N = 8;

    // ------------------------------------------------------------------------
    // CCI-P c0 header subset
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef struct packed {
        logic [1:0]   vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [1:0]   vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        logic [15:0]  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    // ------------------------------------------------------------------------
    // Arbiter FSM
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } t_arb_state;

    // Number of cache lines a request occupies (cl_len encodes lines-1)
    function automatic logic [2:0] cl_count(input t_ccip_clLen len);
        return {1'b0, len} + 3'd1;
    endfunction

    // One-hot pick of the first set bit of valid, searching upward from ptr
    // and wrapping at n. Bits at or above n are never set.
    function automatic logic [RR_MAX_N-1:0] rr_pick(
        input logic [RR_MAX_N-1:0] valid,
        input logic [2:0]          ptr,
        input int                  n
    );
        logic [RR_MAX_N-1:0] pick;
        logic                found;
        logic [2:0]          idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX_N; k++) begin
            idx = 3'((int'(ptr) + k) % n);
            if (k < n && !found && valid[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage : ccip_arb_pkg
`default_nettype wire

// File: rtl/ccip_c0_rd_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : ccip_rr_arbiter
// Description : N-way round-robin arbiter. Grants at most one eligible
//               requester per cycle, searching from the pointer; the pointer
//               moves just past the winner and holds when nothing is granted.
// Revision    : 1.0 - initial release
// ============================================================================
module ccip_rr_arbiter
    import ccip_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N-1:0]     req_i,
    input  logic             enable_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_d;
    logic [RR_MAX_N-1:0] pick_full;

    assign pick_full = rr_pick(RR_MAX_N'(req_i), 3'(ptr_q), N);
    assign grant_o   = enable_i ? pick_full[N-1:0] : '0;
    assign ptr_o     = ptr_q;

    // Upper pick bits are always zero when N is below the helper width
    generate
        if (N < RR_MAX_N) begin : g_pick_pad
            logic [RR_MAX_N-N-1:0] pick_hi_unused;
            assign pick_hi_unused = pick_full[RR_MAX_N-1:N];
        end
    endgenerate

    // Next pointer: one past the granted index, unchanged when idle
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < N; i++) begin
            if (grant_o[i]) begin
                ptr_d = (i == N - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : ccip_rr_arbiter
`default_nettype wire

// File: rtl/ccip_c0_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ccip_c0_rd_arbiter
// Description : Shares the CCI-P c0 read request channel among N_REQ
//               requesters, tags mdata with the requester index, routes read
//               responses back by tag, bounds outstanding cache lines and
//               offers a drain handshake for quiescing read traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module ccip_c0_rd_arbiter
    import ccip_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int TAG_W        = $clog2(N_REQ),
    parameter int MAX_OUTST_CL = 128,
    parameter int CNT_W        = $clog2(MAX_OUTST_CL + 1)
) (
    input  logic                                 pClk,
    input  logic                                 pck_cp2af_softReset_n,
    input  logic [N_REQ-1:0]                     req_valid,
    input  t_ccip_c0_ReqMemHdr [N_REQ-1:0]       req_hdr,
    output logic [N_REQ-1:0]                     req_ready,
    input  logic                                 c0TxAlmFull,
    output t_if_ccip_c0_Tx                       c0_tx,
    input  t_if_ccip_c0_Rx                       c0_rx,
    output logic [N_REQ-1:0]                     rsp_valid,
    output t_if_ccip_c0_Rx                       rsp,
    input  logic                                 drain_req,
    output logic                                 drain_done,
    output logic [CNT_W-1:0]                     outst_cl,
    output logic                                 err_underflow
);

    localparam int PTR_W = $clog2(N_REQ);

    t_arb_state         state_q;
    t_arb_state         state_d;
    logic [CNT_W-1:0]   outst_q;
    logic [CNT_W-1:0]   outst_d;
    logic               err_q;
    logic               err_d;
    t_if_ccip_c0_Tx     tx_q;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [N_REQ-1:0]   rsp_valid_d;
    t_if_ccip_c0_Rx     rsp_q;

    logic [N_REQ-1:0]   fit;
    logic [N_REQ-1:0]   grant;
    logic               arb_en;
    logic [PTR_W-1:0]   rr_ptr_unused;   // pointer kept for debug visibility
    logic [TAG_W-1:0]   gnt_idx;
    logic [2:0]         gnt_cl;
    t_ccip_c0_ReqMemHdr tagged_hdr;

    logic               rd_rsp;
    logic [TAG_W-1:0]   rsp_tag;
    logic               tag_ok;
    t_if_ccip_c0_Rx     rsp_clean;

    // A requester is a candidate only if its whole burst fits under the cap
    always_comb begin
        fit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            fit[i] = (({1'b0, outst_q} + (CNT_W+1)'(cl_count(req_hdr[i].cl_len)))
                      <= (CNT_W+1)'(MAX_OUTST_CL));
        end
    end

    // drain_req gates grants combinationally so none slip out while entering DRAIN
    assign arb_en = (state_q == RUN) && !drain_req && !c0TxAlmFull;

    ccip_rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .clk_i    (pClk),
        .rst_n_i  (pck_cp2af_softReset_n),
        .req_i    (req_valid & fit),
        .enable_i (arb_en),
        .grant_o  (grant),
        .ptr_o    (rr_ptr_unused)
    );

    assign req_ready = grant;

    // Winner index, its burst size and the header with the index stamped in
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx = TAG_W'(i);
            end
        end
        gnt_cl     = (|grant) ? cl_count(req_hdr[gnt_idx].cl_len) : 3'd0;
        tagged_hdr = req_hdr[gnt_idx];
        tagged_hdr.mdata[MDATA_TAG_MSB -: TAG_W] = gnt_idx;
    end

    // Response decode: only read-line completions are routed and counted
    always_comb begin
        rd_rsp    = c0_rx.rspValid && (c0_rx.hdr.resp_type == eRSP_RDLINE);
        rsp_tag   = c0_rx.hdr.mdata[MDATA_TAG_MSB -: TAG_W];
        tag_ok    = (32'(rsp_tag) < 32'(N_REQ));
        rsp_clean = c0_rx;
        rsp_clean.hdr.mdata[MDATA_TAG_MSB -: TAG_W] = '0;
        rsp_valid_d = (rd_rsp && tag_ok) ? (N_REQ'(1) << rsp_tag) : '0;
    end

    // Outstanding count: add the granted burst, retire one line per read
    // completion, saturate at zero and flag any underflow or stray tag
    always_comb begin
        outst_d = outst_q + CNT_W'(gnt_cl);
        err_d   = err_q;
        if (rd_rsp) begin
            if (outst_q == '0) begin
                err_d = 1'b1;
            end else begin
                outst_d = outst_d - CNT_W'(1);
            end
            if (!tag_ok) begin
                err_d = 1'b1;
            end
        end
    end

    // Drain FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_req)           state_d = DRAIN;
            DRAIN:   if (!drain_req)          state_d = RUN;
                     else if (outst_q == '0)  state_d = DONE;
            DONE:    if (!drain_req)          state_d = RUN;
            default:                          state_d = RUN;
        endcase
    end

    // Control state: FSM, counter and sticky error
    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            state_q <= RUN;
            outst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            err_q   <= err_d;
        end
    end

    // Registered request issue; header holds between issues
    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            tx_q <= '0;
        end else begin
            tx_q.valid <= |grant;
            if (|grant) begin
                tx_q.hdr <= tagged_hdr;
            end
        end
    end

    // Registered response routing; payload holds between responses
    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            rsp_valid_q <= '0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (|rsp_valid_d) begin
                rsp_q <= rsp_clean;
            end
        end
    end

    assign c0_tx         = tx_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp           = rsp_q;
    assign drain_done    = (state_q == DONE);
    assign outst_cl      = outst_q;
    assign err_underflow = err_q;

endmodule : ccip_c0_rd_arbiter
`default_nettype wire

// File: tb/tb_ccip_c0_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccip_c0_rd_arbiter
// Description : Self-checking bench for ccip_c0_rd_arbiter. Expected issues
//               and responses are queued when stimulus is applied and popped
//               when the design's registered outputs are due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccip_c0_rd_arbiter;
    import ccip_arb_pkg::*;

    localparam int N = 4;

    logic                         pClk = 1'b0;
    logic                         rst_n;
    logic [N-1:0]                 req_valid;
    t_ccip_c0_ReqMemHdr [N-1:0]   req_hdr;
    logic [N-1:0]                 req_ready;
    logic                         alm;
    t_if_ccip_c0_Tx               c0_tx;
    t_if_ccip_c0_Rx               c0_rx;
    logic [N-1:0]                 rsp_valid;
    t_if_ccip_c0_Rx               rsp;
    logic                         drain_req;
    logic                         drain_done;
    logic [7:0]                   outst_cl;
    logic                         err;

    ccip_c0_rd_arbiter #(
        .N_REQ        (N),
        .MAX_OUTST_CL (128)
    ) dut (
        .pClk                  (pClk),
        .pck_cp2af_softReset_n (rst_n),
        .req_valid             (req_valid),
        .req_hdr               (req_hdr),
        .req_ready             (req_ready),
        .c0TxAlmFull           (alm),
        .c0_tx                 (c0_tx),
        .c0_rx                 (c0_rx),
        .rsp_valid             (rsp_valid),
        .rsp                   (rsp),
        .drain_req             (drain_req),
        .drain_done            (drain_done),
        .outst_cl              (outst_cl),
        .err_underflow         (err)
    );

    always #5 pClk = ~pClk;

    int cyc = 0;
    always @(posedge pClk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [15:0] mdata;
        logic [41:0] addr;
    } t_exp_tx;

    typedef struct {
        int          due;
        logic [3:0]  onehot;
        logic [15:0] mdata;
    } t_exp_rsp;

    t_exp_tx  txq[$];
    t_exp_rsp rspq[$];

    int   n_checks = 0;
    int   n_errors = 0;
    logic mon_en   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Registered-output monitor, sampled a few ns after the active edge
    always @(posedge pClk) begin
        #3;
        if (mon_en) begin
            while (txq.size() > 0 && txq[0].due < cyc) begin
                check("tx_missing", 64'(c0_tx.valid), 64'd1);
                void'(txq.pop_front());
            end
            if (txq.size() > 0 && txq[0].due == cyc) begin
                check("tx_valid", 64'(c0_tx.valid), 64'd1);
                check("tx_mdata", 64'(c0_tx.hdr.mdata), 64'(txq[0].mdata));
                check("tx_addr", 64'(c0_tx.hdr.address), 64'(txq[0].addr));
                void'(txq.pop_front());
            end else if (c0_tx.valid !== 1'b0) begin
                check("tx_spurious", 64'(c0_tx.valid), 64'd0);
            end

            while (rspq.size() > 0 && rspq[0].due < cyc) begin
                check("rsp_missing", 64'(rsp_valid), 64'(rspq[0].onehot));
                void'(rspq.pop_front());
            end
            if (rspq.size() > 0 && rspq[0].due == cyc) begin
                check("rsp_valid", 64'(rsp_valid), 64'(rspq[0].onehot));
                check("rsp_mdata", 64'(rsp.hdr.mdata), 64'(rspq[0].mdata));
                void'(rspq.pop_front());
            end else if (rsp_valid !== '0) begin
                check("rsp_spurious", 64'(rsp_valid), 64'd0);
            end
        end
    end

    task automatic set_hdr(input int i, input t_ccip_clLen len);
        req_hdr[i]          = '0;
        req_hdr[i].address  = 42'h1000 + 42'(i);
        req_hdr[i].mdata    = 16'h0020 + 16'(i);
        req_hdr[i].cl_len   = len;
        req_hdr[i].req_type = eREQ_RDLINE_I;
    endtask

    // Present a response for one cycle; queue its routed result if it is a read
    task automatic drive_rsp(input int tag, input logic [13:0] low, input t_ccip_c0_rsp typ);
        t_exp_rsp e;
        c0_rx.hdr.mdata     = {2'(tag), low};
        c0_rx.hdr.resp_type = typ;
        c0_rx.data          = {16{32'hCAFE_0000 | 32'(tag)}};
        c0_rx.rspValid      = 1'b1;
        if (typ == eRSP_RDLINE) begin
            e.due    = cyc + 1;
            e.onehot = 4'(1) << tag;
            e.mdata  = {2'b00, low};
            rspq.push_back(e);
        end
    endtask

    // One clock: check the combinational grant, queue the expected issue
    task automatic cycle(input logic [3:0] exp_ready);
        @(negedge pClk);
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        for (int i = 0; i < N; i++) begin
            if (exp_ready[i]) begin
                t_exp_tx e;
                e.due   = cyc + 1;
                e.addr  = req_hdr[i].address;
                e.mdata = req_hdr[i].mdata | (16'(i) << 14);
                txq.push_back(e);
            end
        end
        @(posedge pClk);
        #1;
        c0_rx.rspValid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        alm       = 1'b0;
        drain_req = 1'b0;
        c0_rx     = '0;
        for (int i = 0; i < N; i++) set_hdr(i, eCL_LEN_1);
        repeat (3) @(posedge pClk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Reset state
        check("rst_outst", 64'(outst_cl), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_drain_done", 64'(drain_done), 64'd0);
        check("rst_tx_valid", 64'(c0_tx.valid), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);

        // All requesters busy: strict rotation 0,1,2,3,...
        req_valid = 4'hF;
        for (int k = 0; k < 12; k++) cycle(4'(1) << (k % 4));
        req_valid = '0;
        check("rr_outst", 64'(outst_cl), 64'd12);
        cycle(4'h0);
        for (int k = 0; k < 12; k++) begin
            drive_rsp(k % 4, 14'(k + 3), eRSP_RDLINE);
            cycle(4'h0);
        end
        check("rr_outst_ret", 64'(outst_cl), 64'd0);

        // almFull blocks grants; first grant in the cycle it drops
        req_valid = 4'hF;
        alm       = 1'b1;
        repeat (5) cycle(4'h0);
        alm = 1'b0;
        cycle(4'b0001);
        req_valid = '0;
        cycle(4'h0);
        check("alm_outst", 64'(outst_cl), 64'd1);
        drive_rsp(0, 14'h11, eRSP_RDLINE);
        cycle(4'h0);
        check("alm_outst_ret", 64'(outst_cl), 64'd0);

        // Outstanding cap: 32 x 4 CL fills 128 exactly
        set_hdr(1, eCL_LEN_4);
        req_valid = 4'b0010;
        repeat (32) cycle(4'b0010);
        check("cap_full", 64'(outst_cl), 64'd128);
        repeat (2) cycle(4'h0);
        for (int k = 0; k < 4; k++) begin
            drive_rsp(1, 14'(k), eRSP_RDLINE);
            cycle(4'h0);
        end
        cycle(4'b0010);
        cycle(4'h0);
        req_valid = '0;
        check("cap_refill", 64'(outst_cl), 64'd128);

        // Drain the 128 lines; includes the tag-2 routing case and a non-read
        for (int k = 0; k < 128; k++) begin
            if (k == 5) drive_rsp(2, 14'h1A5, eRSP_RDLINE);
            else        drive_rsp(k % 4, 14'(k), eRSP_RDLINE);
            cycle(4'h0);
            if (k == 64) begin
                drive_rsp(3, 14'h3FF, eRSP_UMSG);
                cycle(4'h0);
                check("nonread_nodec", 64'(outst_cl), 64'd63);
            end
        end
        check("cap_empty", 64'(outst_cl), 64'd0);
        check("cap_err", 64'(err), 64'd0);

        // Drain handshake with 3 lines outstanding
        set_hdr(2, eCL_LEN_1);
        req_valid = 4'b0100;
        repeat (3) cycle(4'b0100);
        drain_req = 1'b1;
        cycle(4'h0);
        check("drain_outst", 64'(outst_cl), 64'd3);
        for (int k = 0; k < 3; k++) begin
            check("drain_pending", 64'(drain_done), 64'd0);
            drive_rsp(2, 14'(k + 40), eRSP_RDLINE);
            cycle(4'h0);
        end
        check("drain_zero", 64'(outst_cl), 64'd0);
        check("drain_not_yet", 64'(drain_done), 64'd0);
        cycle(4'h0);
        check("drain_done", 64'(drain_done), 64'd1);
        cycle(4'h0);
        check("drain_hold", 64'(drain_done), 64'd1);
        drain_req = 1'b0;
        cycle(4'h0);
        check("drain_release", 64'(drain_done), 64'd0);
        cycle(4'b0100);
        req_valid = '0;
        cycle(4'h0);
        check("resume_outst", 64'(outst_cl), 64'd1);

        // Mid-traffic reset then a late response
        set_hdr(0, eCL_LEN_2);
        req_valid = 4'b0001;
        cycle(4'b0001);
        req_valid = '0;
        cycle(4'h0);
        check("pre_rst_outst", 64'(outst_cl), 64'd3);
        cycle(4'h0);
        rst_n = 1'b0;
        cycle(4'h0);
        rst_n = 1'b1;
        check("mid_rst_outst", 64'(outst_cl), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        check("mid_rst_tx", 64'(c0_tx.valid), 64'd0);
        drive_rsp(0, 14'h77, eRSP_RDLINE);
        cycle(4'h0);
        check("late_outst", 64'(outst_cl), 64'd0);
        check("late_err", 64'(err), 64'd1);
        repeat (3) cycle(4'h0);
        check("late_err_sticky", 64'(err), 64'd1);
        check("late_outst_sat", 64'(outst_cl), 64'd0);

        repeat (2) cycle(4'h0);
        check("txq_empty", 64'(txq.size()), 64'd0);
        check("rspq_empty", 64'(rspq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ccip_c0_rd_arbiter
`default_nettype wire

// File: doc/ccip_c0_rd_arbiter.md
Name: ccip_c0_rd_arbiter

Overview:
- Shares the CCI-P c0 (memory read) request channel among N_REQ requesters in the green region, using round-robin arbitration.
- Tags each request's mdata with the requester index, and routes c0 read responses back to the owning requester by that tag.
- Enforces c0TxAlmFull and a global outstanding-cache-line limit.
- Provides a drain handshake so software-visible resets or reconfiguration can quiesce read traffic before the registered CCI-P interface stage is touched.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- TAG_W, $clog2(N_REQ): mdata tag width, occupying mdata[15:16-TAG_W].
- MAX_OUTST_CL, 128: maximum cache lines in flight.
- CNT_W, $clog2(MAX_OUTST_CL+1): outstanding counter width.

Ports:
- pClk  in  1  CCI-P primary clock; all logic on its rising edge.
- pck_cp2af_softReset_n  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  per-requester read request valid.
- req_hdr  in  N_REQ x t_ccip_c0_ReqMemHdr  request header; mdata[15:16-TAG_W] must be zero.
- req_ready  out  N_REQ  one-hot grant; request accepted when valid&ready.
- c0TxAlmFull  in  1  from registered sRx.
- c0_tx  out  t_if_ccip_c0_Tx  registered request to sTx.c0.
- c0_rx  in  t_if_ccip_c0_Rx  from registered sRx.c0.
- rsp_valid  out  N_REQ  one-hot response valid.
- rsp  out  t_if_ccip_c0_Rx  response payload, tag bits cleared; shared across requesters.
- drain_req  in  1  level request to stop issuing.
- drain_done  out  1  no grants and zero outstanding.
- outst_cl  out  CNT_W  current outstanding cache lines.
- err_underflow  out  1  sticky; response arrived with counter at 0.

Behaviour:
- Reset, synchronous and active-low: all outputs 0, rr pointer=0, FSM=RUN, outst_cl=0, err_underflow=0.
- Grant eligibility requires all of:
  - FSM==RUN
  - !c0TxAlmFull (combinational)
  - outst_cl + (cl_len+1) <= MAX_OUTST_CL for the candidate.
- req_ready is combinational, at most one bit set.
- Round robin: search starts at the pointer index. After a grant to i, pointer <= (i+1) mod N_REQ. No grant leaves the pointer unchanged.
- Issue: the cycle after the grant, c0_tx.valid=1 and c0_tx.hdr=req_hdr[i] with mdata[15:16-TAG_W]=i. Otherwise c0_tx.valid=0 and hdr holds its last value. Latency is 1 cycle; at most one request per cycle.
- Counter: outst_cl += cl_len+1 on grant. It decrements by 1 per c0_rx.rspValid with resp_type==eRSP_RDLINE; each CL response counts once.
  - Simultaneous grant and response: net update in one cycle.
  - A decrement at 0 saturates at 0 and sets err_underflow.
- Response routing: registered, 1-cycle latency.
  - rsp_valid[tag]=1 when c0_rx.rspValid and resp_type is read.
  - rsp = c0_rx with the tag bits zeroed.
  - Non-read responses (mmio req, write fence on c0) are dropped and all rsp_valid=0.
  - Tag >= N_REQ: dropped, and err_underflow is set.
- FSM:
  - RUN -> DRAIN when drain_req=1. No new grants from that cycle on.
  - DRAIN -> DONE when outst_cl==0. drain_done=1 only in DONE.
  - DONE -> RUN when drain_req=0. Grants may resume the following cycle.
  - drain_req deasserted while in DRAIN -> RUN.
- c0TxAlmFull asserting in the grant cycle blocks that grant. An already-granted request still issues next cycle; the CCI-P almFull slack covers it.
- Reset mid-operation: counter and FSM are cleared. Late responses still route by tag; decrements saturate and set err_underflow.

Decomposition:
- Shared package ccip_arb_pkg holds:
  - t_arb_state enum {RUN, DRAIN, DONE}
  - MDATA_TAG_MSB = 15
  - function rr_pick(valid, ptr), returning a one-hot vector.
- Sub-module ccip_rr_arbiter is natural: N-way round-robin, with inputs req/enable and outputs grant/ptr update. It is reusable for the c1 write channel.
- Response routing and the counter stay in the top level.

Test Plan:
- Reset, then all 4 requesters valid with cl_len=0 continuously: grants in order 0,1,2,3,0…; c0_tx.valid every cycle; c0_tx.mdata[15:14] equals the granted index.
- c0TxAlmFull=1 for 5 cycles with requests pending: req_ready=0 for those 5 cycles; the first grant comes in the cycle almFull drops.
- Issue 32 requests with cl_len=eCL_LEN_4 (128 CL): outst_cl=128; a further request is not granted until 4 responses arrive, then exactly one grant.
- A response with mdata tag=2, mdata[13:0]=0x1A5: rsp_valid=4'b0100 one cycle later and rsp.hdr.mdata=0x01A5.
- drain_req=1 with 3 CL outstanding: no grants; drain_done rises the cycle after the 3rd response lands. Drop drain_req: grants resume.
- Response arriving with outst_cl=0 after a mid-traffic reset: outst_cl stays 0, err_underflow=1 and sticky until reset.
